// File: rtl/lighthouse_pulse_generator_pkg.sv
// Shared types and the LFSR step for the Lighthouse V2 sweep-pulse generator.
// The step function is also used by verification reference models.
package lighthouse_pulse_generator_pkg;

    localparam int unsigned LFSR_W = 17;
    localparam int unsigned TS_W   = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_EMIT,
        ST_TAIL
    } pulse_state_e;

    // Fibonacci step: returns {fb, next_state}; fb is also the emitted bit.
    function automatic logic [LFSR_W:0] lfsr_next(
        input logic [LFSR_W-1:0] state,
        input logic [LFSR_W-1:0] poly
    );
        logic fb;
        fb = ^(state & poly);
        return {fb, state[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lighthouse_pulse_generator_bmc_encoder_tx.sv
// Biphase-Mark transmit encoder: owns the line level and the half-bit timing.
// A bit is taken when idle or exactly at the end of the current bit period.
module bmc_encoder_tx #(
    parameter int unsigned HALF_BIT_TICKS = 8
) (
    input  logic clk_96MHz,
    input  logic reset,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_taken,
    output logic bmc_out
);

    localparam int unsigned CNT_W = $clog2(HALF_BIT_TICKS) + 1;
    localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(HALF_BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * HALF_BIT_TICKS - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             bmc_q, bmc_d;
    logic             bit_end;

    assign bit_end   = active_q && (cnt_q == BIT_LAST);
    assign bit_taken = bit_valid && (!active_q || bit_end);
    assign bmc_out   = bmc_q;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        bmc_d    = bmc_q;
        if (active_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == MID_LAST && bit_q) begin
                bmc_d = ~bmc_q;
            end
            if (bit_end) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end
        end
        // A new bit always starts with a transition; a one adds a mid-bit one.
        if (bit_taken) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = bit_in;
            bmc_d    = ~bmc_q;
        end
        if (clear) begin
            active_d = 1'b0;
            cnt_d    = '0;
            bit_d    = 1'b0;
            bmc_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 1'b0;
            bmc_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            bmc_q    <= bmc_d;
        end
    end

endmodule

// File: rtl/lighthouse_pulse_generator.sv
// Lighthouse V2 sweep-pulse transmitter: seeks the LFSR, then emits BMC bits under an envelope.
// Optional PULSE_GEN_TIMESTAMP_EN captures a free-running 24-bit counter at envelope rise.
module lighthouse_pulse_generator
    import lighthouse_pulse_generator_pkg::*;
#(
    parameter int unsigned HALF_BIT_TICKS = 8,
    parameter logic [16:0] LFSR_SEED      = 17'h00001,
    parameter int unsigned MAX_BITS_W     = 8
) (
    input  logic                  clk_96MHz,
    input  logic                  reset,
    input  logic                  start,
    input  logic [16:0]           polynomial,
    input  logic [16:0]           offset,
    input  logic [MAX_BITS_W-1:0] num_bits,
    output logic                  bmc_out,
    output logic                  envelope,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [16:0]           lfsr_at_start,
    output logic [23:0]           ts_start
);

    // Tail ends one full bit after the last bit finishes: two bit periods after it is taken.
    localparam int unsigned TAIL_W = $clog2(4 * HALF_BIT_TICKS);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(4 * HALF_BIT_TICKS - 1);

    pulse_state_e          state_q, state_d;
    logic [LFSR_W-1:0]     poly_q, poly_d;
    logic [MAX_BITS_W-1:0] num_q, num_d;
    logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]     seek_q, seek_d;
    logic [MAX_BITS_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TAIL_W-1:0]     tail_q, tail_d;
    logic                  env_q, env_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [LFSR_W-1:0]     las_q, las_d;

    logic              fb;
    logic [LFSR_W-1:0] lfsr_step;
    logic              bit_valid;
    logic              bit_taken;
    logic              enc_clear;

    assign {fb, lfsr_step} = lfsr_next(lfsr_q, poly_q);
    assign bit_valid = ((state_q == ST_SEEK) && (seek_q == '0)) || (state_q == ST_EMIT);

    bmc_encoder_tx #(
        .HALF_BIT_TICKS(HALF_BIT_TICKS)
    ) u_bmc_encoder_tx (
        .clk_96MHz(clk_96MHz),
        .reset    (reset),
        .clear    (enc_clear),
        .bit_in   (fb),
        .bit_valid(bit_valid),
        .bit_taken(bit_taken),
        .bmc_out  (bmc_out)
    );

    always_comb begin
        state_d   = state_q;
        poly_d    = poly_q;
        num_d     = num_q;
        lfsr_d    = lfsr_q;
        seek_d    = seek_q;
        bit_cnt_d = bit_cnt_q;
        tail_d    = tail_q;
        env_d     = env_q;
        busy_d    = busy_q;
        las_d     = las_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        enc_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (polynomial == '0) begin
                        error_d = 1'b1;
                    end else if (num_bits == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_SEEK;
                        poly_d    = polynomial;
                        num_d     = num_bits;
                        lfsr_d    = LFSR_SEED;
                        seek_d    = offset;
                        bit_cnt_d = '0;
                        busy_d    = 1'b1;
                    end
                end
            end
            ST_SEEK: begin
                if (seek_q != '0) begin
                    lfsr_d = lfsr_step;
                    seek_d = seek_q - 1'b1;
                end
            end
            ST_EMIT: begin
            end
            ST_TAIL: begin
                tail_d = tail_q + 1'b1;
                if (tail_q == TAIL_LAST) begin
                    state_d   = ST_IDLE;
                    tail_d    = '0;
                    env_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    enc_clear = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The first bit is taken on the same edge that leaves SEEK and raises the envelope.
        if (bit_taken) begin
            lfsr_d    = lfsr_step;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (state_q == ST_SEEK) begin
                env_d = 1'b1;
                las_d = lfsr_q;
            end
            if (bit_cnt_d == num_q) begin
                state_d = ST_TAIL;
                tail_d  = '0;
            end else begin
                state_d = ST_EMIT;
            end
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            poly_q    <= '0;
            num_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            seek_q    <= '0;
            bit_cnt_q <= '0;
            tail_q    <= '0;
            env_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            las_q     <= '0;
        end else begin
            state_q   <= state_d;
            poly_q    <= poly_d;
            num_q     <= num_d;
            lfsr_q    <= lfsr_d;
            seek_q    <= seek_d;
            bit_cnt_q <= bit_cnt_d;
            tail_q    <= tail_d;
            env_q     <= env_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            las_q     <= las_d;
        end
    end

`ifdef PULSE_GEN_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0] ts_start_q, ts_start_d;
    logic            env_rise;

    assign env_rise = bit_taken && (state_q == ST_SEEK);

    always_comb begin
        ts_cnt_d   = ts_cnt_q + 1'b1;
        ts_start_d = env_rise ? ts_cnt_q : ts_start_q;
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            ts_cnt_q   <= '0;
            ts_start_q <= '0;
        end else begin
            ts_cnt_q   <= ts_cnt_d;
            ts_start_q <= ts_start_d;
        end
    end

    assign ts_start = ts_start_q;
`else
    assign ts_start = '0;
`endif

    assign envelope      = env_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign lfsr_at_start = las_q;

endmodule

// File: tb/tb_lighthouse_pulse_generator.sv
// Directed self-checking bench for lighthouse_pulse_generator; decodes the BMC line
// per bit period and compares against hand-computed LFSR sequences.
module tb_lighthouse_pulse_generator;

    localparam int LIMIT = 4000;

    logic        clk_96MHz = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic [16:0] polynomial = '0;
    logic [16:0] offset     = '0;
    logic [7:0]  num_bits   = '0;
    logic        bmc_out, envelope, busy, done, error;
    logic [16:0] lfsr_at_start;
    logic [23:0] ts_start;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] mcnt;

    lighthouse_pulse_generator #(
        .HALF_BIT_TICKS(8),
        .LFSR_SEED     (17'h00001),
        .MAX_BITS_W    (8)
    ) dut (
        .clk_96MHz    (clk_96MHz),
        .reset        (reset),
        .start        (start),
        .polynomial   (polynomial),
        .offset       (offset),
        .num_bits     (num_bits),
        .bmc_out      (bmc_out),
        .envelope     (envelope),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .lfsr_at_start(lfsr_at_start),
        .ts_start     (ts_start)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    // Reference cycle count since reset, same timebase the timestamp counter uses.
    always @(posedge clk_96MHz) begin
        if (reset) mcnt <= '0;
        else       mcnt <= mcnt + 24'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue a pulse request and record the line until the envelope falls.
    task automatic run_pulse(
        input  logic [16:0] poly,
        input  logic [16:0] off,
        input  logic [7:0]  n,
        input  int          poke,
        output int          delay,
        output int          env_len,
        output int          toggles,
        output logic [31:0] bits,
        output logic        tail_ok,
        output logic        err_seen,
        output logic        done_ok,
        output logic [23:0] acc
    );
        logic samp[$];
        logic prev;
        int   nb;
        @(negedge clk_96MHz);
        polynomial = poly; offset = off; num_bits = n; start = 1'b1;
        @(negedge clk_96MHz);
        start = 1'b0;
        acc = mcnt - 24'd1;
        err_seen = error;
        delay = 0;
        while (!envelope && delay < LIMIT) begin
            @(negedge clk_96MHz);
            delay++;
        end
        env_len = 0;
        while (envelope && env_len < LIMIT) begin
            samp.push_back(bmc_out);
            start = (env_len == poke);
            if (env_len == poke) polynomial = '0;
            @(negedge clk_96MHz);
            err_seen |= error;
            env_len++;
        end
        start = 1'b0;
        done_ok = done && !busy && !bmc_out;
        @(negedge clk_96MHz);
        done_ok &= !done;
        toggles = 0; prev = 1'b0;
        foreach (samp[i]) begin
            if (samp[i] != prev) toggles++;
            prev = samp[i];
        end
        nb = env_len / 16 - 1;
        bits = '0;
        tail_ok = (nb > 0);
        if (nb > 0) begin
            for (int k = 0; k < nb; k++) bits = {bits[30:0], samp[16*k] != samp[16*k+8]};
            for (int i = 16*nb; i < 16*nb + 16; i++) if (samp[i] != samp[16*nb-1]) tail_ok = 1'b0;
        end
    endtask

    initial begin
        int d, el, tg;
        logic [31:0] bits;
        logic tail_ok, err_seen, done_ok;
        logic [23:0] acc;

        repeat (3) @(negedge clk_96MHz);
        check_eq("rst_outputs", {bmc_out, envelope, busy, done, error}, 5'b0);
        check_eq("rst_lfsr_at_start", lfsr_at_start, 0);
        check_eq("rst_ts", ts_start, 0);
        reset = 1'b0;

        // poly 1: all ones, toggles every half bit
        run_pulse(17'h00001, 17'd0, 8'd4, -1, d, el, tg, bits, tail_ok, err_seen, done_ok, acc);
        check_eq("t1_delay", d, 1);
        check_eq("t1_env_len", el, 80);
        check_eq("t1_toggles", tg, 8);
        check_eq("t1_bits", bits, 32'hF);
        check_eq("t1_tail", tail_ok, 1);
        check_eq("t1_done", done_ok, 1);
        check_eq("t1_las", lfsr_at_start, 17'h00001);
        check_eq("t1_no_err", err_seen, 0);

        // poly MSB tap: 16 zeros then a one
        run_pulse(17'h10000, 17'd0, 8'd17, -1, d, el, tg, bits, tail_ok, err_seen, done_ok, acc);
        check_eq("t2_env_len", el, 18*16);
        check_eq("t2_toggles", tg, 18);
        check_eq("t2_bits", bits, 32'h00001);
        check_eq("t2_tail", tail_ok, 1);
        check_eq("t2_done", done_ok, 1);
        check_eq("t2_las", lfsr_at_start, 17'h00001);

        // offset 16 lands exactly on the one bit
        run_pulse(17'h10000, 17'd16, 8'd1, -1, d, el, tg, bits, tail_ok, err_seen, done_ok, acc);
        check_eq("t3_delay", d, 17);
        check_eq("t3_env_len", el, 32);
        check_eq("t3_toggles", tg, 2);
        check_eq("t3_bits", bits, 1);
        check_eq("t3_las", lfsr_at_start, 17'h10000);
        check_eq("t3_done", done_ok, 1);

        // zero polynomial rejected
        @(negedge clk_96MHz);
        polynomial = '0; num_bits = 8'd4; start = 1'b1;
        @(negedge clk_96MHz);
        start = 1'b0;
        check_eq("t4_err_pulse", {error, done, busy}, 3'b100);
        @(negedge clk_96MHz);
        check_eq("t4_err_clear", {error, busy, envelope}, 3'b000);

        // zero length: done only
        @(negedge clk_96MHz);
        polynomial = 17'h00001; num_bits = 8'd0; start = 1'b1;
        @(negedge clk_96MHz);
        start = 1'b0;
        check_eq("t5_done_pulse", {done, error, busy, envelope}, 4'b1000);
        @(negedge clk_96MHz);
        check_eq("t5_done_clear", done, 0);

        // start while busy is ignored
        run_pulse(17'h00001, 17'd0, 8'd4, 20, d, el, tg, bits, tail_ok, err_seen, done_ok, acc);
        check_eq("t6_env_len", el, 80);
        check_eq("t6_bits", bits, 32'hF);
        check_eq("t6_no_err", err_seen, 0);
        check_eq("t6_done", done_ok, 1);

        // reset mid-EMIT aborts
        @(negedge clk_96MHz);
        polynomial = 17'h00001; offset = 17'd3; num_bits = 8'd8; start = 1'b1;
        @(negedge clk_96MHz);
        start = 1'b0;
        for (int i = 0; i < 30; i++) @(negedge clk_96MHz);
        check_eq("t7_in_pulse", {envelope, busy}, 2'b11);
        reset = 1'b1;
        @(negedge clk_96MHz);
        check_eq("t7_abort", {bmc_out, envelope, busy, done}, 4'b0);
        reset = 1'b0;

        // all-zero bits after seek of 2 (LFSR = 4)
        run_pulse(17'h10000, 17'd2, 8'd3, -1, d, el, tg, bits, tail_ok, err_seen, done_ok, acc);
        check_eq("t8_delay", d, 3);
        check_eq("t8_env_len", el, 64);
        check_eq("t8_toggles", tg, 3);
        check_eq("t8_bits", bits, 0);
        check_eq("t8_las", lfsr_at_start, 17'h00004);

        // two-tap polynomial: 1,0,1
        run_pulse(17'h00003, 17'd0, 8'd3, -1, d, el, tg, bits, tail_ok, err_seen, done_ok, acc);
        check_eq("t9_bits", bits, 32'b101);
        check_eq("t9_toggles", tg, 5);
        check_eq("t9_tail", tail_ok, 1);

        // timestamp at envelope rise
        run_pulse(17'h00001, 17'd5, 8'd2, -1, d, el, tg, bits, tail_ok, err_seen, done_ok, acc);
        check_eq("t10_delay", d, 6);
`ifdef PULSE_GEN_TIMESTAMP_EN
        check_eq("t10_ts", ts_start, acc + 24'd6);
`else
        check_eq("t10_ts", ts_start, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
